// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Consumer side of the PLL lock interface. Runs entirely in the PLL output clock domain.
// The asynchronous PLL lock flag is synchronized and must hold for a run of consecutive cycles
// before it counts as stable lock. After that the supervisor keeps downstream logic in reset for
// a few more cycles, then releases reset and raises ready. While running, it emits a periodic
// one-cycle tick and counts every lock loss. The count saturates instead of wrapping.
//
// Ports:
//   clock           PLL output clock; all logic runs on its rising edge
//   reset           synchronous, active-high reset
//   locked          PLL lock flag, asynchronous to clock
//   sys_reset       synchronous active-high reset for downstream logic (high unless RUN)
//   ready           high only while in RUN
//   tick            one-cycle strobe every TICK_DIV cycles while in RUN
//   lock_loss_count number of lock losses seen in RUN, saturating at 255
//   state           current FSM state, for debug (0 WAIT_LOCK, 1 STABILIZE, 2 HOLD_RESET, 3 RUN)

module pll_lock_supervisor #(
    parameter int unsigned STABLE_CYCLES     = 1024,
    parameter int unsigned RESET_HOLD_CYCLES = 16,
    parameter int unsigned TICK_DIV          = 240
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    output logic       sys_reset,
    output logic       ready,
    output logic       tick,
    output logic [7:0] lock_loss_count,
    output logic [1:0] state
);

    localparam int unsigned StableW = $clog2(STABLE_CYCLES) + 1;
    localparam int unsigned HoldW   = $clog2(RESET_HOLD_CYCLES) + 1;
    localparam int unsigned DivW    = $clog2(TICK_DIV) + 1;

    localparam logic [StableW-1:0] StableLast = StableW'(STABLE_CYCLES - 1);
    localparam logic [HoldW-1:0]   HoldLast   = HoldW'(RESET_HOLD_CYCLES - 1);
    localparam logic [DivW-1:0]    DivLast    = DivW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StWaitLock  = 2'd0,
        StStabilize = 2'd1,
        StHoldReset = 2'd2,
        StRun       = 2'd3
    } state_e;

    state_e             state_q;
    logic               sync1_q;
    logic               locked_s_q;
    logic [StableW-1:0] stable_cnt_q;
    logic [HoldW-1:0]   hold_cnt_q;
    logic [DivW-1:0]    div_q;
    logic [7:0]         loss_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            locked_s_q   <= 1'b0;
            state_q      <= StWaitLock;
            stable_cnt_q <= '0;
            hold_cnt_q   <= '0;
            div_q        <= '0;
            loss_cnt_q   <= '0;
        end else begin
            // Two-flop synchronizer for the asynchronous lock flag.
            sync1_q    <= locked;
            locked_s_q <= sync1_q;

            // A lock drop is checked before any terminal count so that a loss arriving on the
            // same cycle a counter completes always wins.
            unique case (state_q)
                StWaitLock: begin
                    if (locked_s_q) begin
                        state_q      <= StStabilize;
                        stable_cnt_q <= '0;
                    end
                end
                StStabilize: begin
                    if (!locked_s_q) begin
                        state_q <= StWaitLock;
                    end else if (stable_cnt_q == StableLast) begin
                        state_q    <= StHoldReset;
                        hold_cnt_q <= '0;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + StableW'(1);
                    end
                end
                StHoldReset: begin
                    if (!locked_s_q) begin
                        state_q <= StWaitLock;
                    end else if (hold_cnt_q == HoldLast) begin
                        state_q <= StRun;
                        div_q   <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HoldW'(1);
                    end
                end
                StRun: begin
                    if (!locked_s_q) begin
                        state_q <= StWaitLock;
                        div_q   <= '0;
                        if (loss_cnt_q != 8'hFF) begin
                            loss_cnt_q <= loss_cnt_q + 8'd1;
                        end
                    end else if (div_q == DivLast) begin
                        div_q <= '0;
                    end else begin
                        div_q <= div_q + DivW'(1);
                    end
                end
                default: begin
                    state_q <= StWaitLock;
                end
            endcase
        end
    end

    // Outputs are decoded straight from registers: no added latency and no combinational inputs.
    assign sys_reset       = (state_q != StRun);
    assign ready           = (state_q == StRun);
    assign tick            = (state_q == StRun) && (div_q == DivLast);
    assign lock_loss_count = loss_cnt_q;
    assign state           = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    localparam int STABLE = 8;
    localparam int HOLD   = 4;
    localparam int TDIV   = 5;

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_STAB = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       sys_reset;
    logic       ready;
    logic       tick;
    logic [7:0] lock_loss_count;
    logic [1:0] state;

    pll_lock_supervisor #(
        .STABLE_CYCLES    (STABLE),
        .RESET_HOLD_CYCLES(HOLD),
        .TICK_DIV         (TDIV)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .locked         (locked),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .tick           (tick),
        .lock_loss_count(lock_loss_count),
        .state          (state)
    );

    always #5 clock = ~clock;

    // Observation word: {state, sys_reset, ready, tick, lock_loss_count}
    logic [12:0] exp_q[$];
    logic [12:0] obs_q[$];
    int checks = 0;
    int errors = 0;
    int run_idx = 0;
    int exp_cnt = 0;

    // Expected trace builders: one entry per clock edge, in order.
    task automatic push_state(input logic [1:0] st, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({st, 1'b1, 1'b0, 1'b0, 8'(exp_cnt)});
        end
        run_idx = 0;
    endtask

    task automatic push_run(input int n);
        logic tk;
        for (int i = 0; i < n; i++) begin
            run_idx++;
            tk = ((run_idx % TDIV) == 0);
            exp_q.push_back({ST_RUN, 1'b0, 1'b1, tk, 8'(exp_cnt)});
        end
    endtask

    task automatic push_bringup();
        push_state(ST_WAIT, 2);
        push_state(ST_STAB, STABLE);
        push_state(ST_HOLD, HOLD);
    endtask

    // Drive n cycles and record what the DUT shows 1 time unit after each rising edge.
    task automatic drive(input logic rst, input logic lk, input int n);
        for (int i = 0; i < n; i++) begin
            reset  = rst;
            locked = lk;
            @(posedge clock);
            #1;
            obs_q.push_back({state, sys_reset, ready, tick, lock_loss_count});
        end
    endtask

    task automatic do_reset(input logic lk);
        exp_cnt = 0;
        push_state(ST_WAIT, 2);
        drive(1'b1, lk, 2);
    endtask

    // From steady RUN: one-cycle lock drop, relock, and come back to one cycle of RUN.
    task automatic lose_once();
        push_run(2);
        if (exp_cnt < 255) exp_cnt++;
        push_state(ST_WAIT, 1);
        push_state(ST_STAB, STABLE);
        push_state(ST_HOLD, HOLD);
        push_run(1);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 15);
    endtask

    task automatic test_reset();
        logic [12:0] e, o;
        do_reset(1'b0);
        push_state(ST_WAIT, 4);
        drive(1'b0, 1'b0, 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 13'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset: got %h expected %h", o, e);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_bringup();
        logic [12:0] e, o;
        do_reset(1'b1);
        push_bringup();
        push_run(12);
        drive(1'b0, 1'b1, 26);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 13'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bringup: got %h expected %h", o, e);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_drop_stabilize();
        logic [12:0] e, o;
        do_reset(1'b1);
        push_state(ST_WAIT, 2);
        push_state(ST_STAB, 5);
        push_state(ST_WAIT, 3);
        push_state(ST_STAB, STABLE);
        push_state(ST_HOLD, HOLD);
        push_run(6);
        drive(1'b0, 1'b1, 5);
        drive(1'b0, 1'b0, 3);
        drive(1'b0, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 13'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL drop_stabilize: got %h expected %h", o, e);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_drop_hold();
        logic [12:0] e, o;
        do_reset(1'b1);
        push_state(ST_WAIT, 2);
        push_state(ST_STAB, STABLE);
        push_state(ST_HOLD, 3);
        push_state(ST_WAIT, 2);
        push_state(ST_STAB, STABLE);
        push_state(ST_HOLD, HOLD);
        push_run(3);
        drive(1'b0, 1'b1, 11);
        drive(1'b0, 1'b0, 2);
        drive(1'b0, 1'b1, 17);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 13'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL drop_hold: got %h expected %h", o, e);
            end
        end
        obs_q.delete();
    endtask

    // Synchronized lock drops exactly on the edge where the stability count would complete.
    task automatic test_simultaneous();
        logic [12:0] e, o;
        do_reset(1'b1);
        push_state(ST_WAIT, 2);
        push_state(ST_STAB, STABLE);
        push_state(ST_WAIT, 1);
        push_state(ST_STAB, STABLE);
        push_state(ST_HOLD, HOLD);
        push_run(2);
        drive(1'b0, 1'b1, 8);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 16);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 13'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL simultaneous: got %h expected %h", o, e);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_run_loss();
        logic [12:0] e, o;
        do_reset(1'b1);
        push_bringup();
        push_run(7);
        drive(1'b0, 1'b1, 21);
        lose_once();
        push_run(6);
        drive(1'b0, 1'b1, 6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 13'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL run_loss: got %h expected %h", o, e);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_saturation();
        logic [12:0] e, o;
        do_reset(1'b1);
        push_bringup();
        push_run(1);
        drive(1'b0, 1'b1, 15);
        for (int i = 0; i < 300; i++) lose_once();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 13'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL saturation: got %h expected %h", o, e);
            end
        end
        obs_q.delete();
        checks++;
        if (lock_loss_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation_final: got %0d expected 255", lock_loss_count);
        end
    endtask

    task automatic test_reset_in_run();
        logic [12:0] e, o;
        do_reset(1'b1);
        push_bringup();
        push_run(1);
        drive(1'b0, 1'b1, 15);
        for (int i = 0; i < 3; i++) lose_once();
        push_run(3);
        drive(1'b0, 1'b1, 3);
        exp_cnt = 0;
        push_state(ST_WAIT, 1);
        drive(1'b1, 1'b1, 1);
        push_bringup();
        push_run(6);
        drive(1'b0, 1'b1, 20);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 13'bx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_in_run: got %h expected %h", o, e);
            end
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_drop_stabilize();
        test_drop_hold();
        test_simultaneous();
        test_run_loss();
        test_saturation();
        test_reset_in_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
